ac97_codec_cra: RTL and testbench



---
 rtl/ac97_codec_cra_if.sv | 22 ++
 rtl/ac97_codec_cra.sv | 134 +++++++++++++
 tb/tb_ac97_codec_cra.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ac97_codec_cra_if.sv
// AC'97 slot 1/2 bus between the controller (master) and the codec register responder (slave).
interface ac97_codec_cra_if;
  logic        valid;
  logic        in_tag1;
  logic        in_tag2;
  logic [19:0] in_slt1;
  logic [19:0] in_slt2;
  logic        out_tag1;
  logic        out_tag2;
  logic [19:0] out_slt1;
  logic [19:0] out_slt2;

  modport master (
    output valid, in_tag1, in_tag2, in_slt1, in_slt2,
    input  out_tag1, out_tag2, out_slt1, out_slt2
  );

  modport slave (
    input  valid, in_tag1, in_tag2, in_slt1, in_slt2,
    output out_tag1, out_tag2, out_slt1, out_slt2
  );
endinterface

// File: rtl/ac97_codec_cra.sv
// Codec-side AC'97 register access responder: decodes slot 1/2 commands,
// holds a 64 x 16 register file and answers reads in the next input frame.
module ac97_codec_cra #(
  parameter logic [15:0] VID1    = 16'h4144,
  parameter logic [15:0] VID2    = 16'h5370,
  parameter logic [15:0] RST_ID  = 16'h0000,
  parameter logic [15:0] VOL_RST = 16'h8000
) (
  input  logic                    clk,
  input  logic                    rst,
  ac97_codec_cra_if.slave         bus,
  output logic                    reg_we,
  output logic [6:0]              reg_addr,
  output logic [15:0]             reg_wdata
);

  typedef enum logic [1:0] {IDLE, WR, RD_PEND, RD_RESP} state_t;

  state_t      state_q, state_d;
  logic        valid_r;
  logic        valid_pe, valid_ne;
  logic        cap_wr, cap_rd;
  logic        take_wr, take_rd, load_rsp, clr_tags;
  logic [6:0]  cmd_addr;
  logic [6:0]  rd_addr;
  logic [15:0] rdata;
  logic [15:0] regs [64];
  logic        unused_bits;

  function automatic logic [15:0] rst_val(input int unsigned idx);
    return (idx == 1 || idx == 2 || idx == 12) ? VOL_RST : 16'h0000;
  endfunction

  assign unused_bits = ^{bus.in_slt1[11:0], bus.in_slt2[3:0]};

  assign valid_pe = bus.valid & ~valid_r;
  assign valid_ne = ~bus.valid & valid_r;
  assign cmd_addr = bus.in_slt1[18:12];
  // Odd addresses are illegal: writes are dropped, reads still answer with zero data.
  assign cap_wr   = valid_ne & bus.in_tag1 & ~bus.in_slt1[19] & bus.in_tag2 & ~cmd_addr[0];
  assign cap_rd   = valid_ne & bus.in_tag1 & bus.in_slt1[19];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    take_wr  = 1'b0;
    take_rd  = 1'b0;
    load_rsp = 1'b0;
    clr_tags = 1'b0;
    case (state_q)
      IDLE: begin
        take_wr = cap_wr;
        take_rd = cap_rd;
        if (cap_wr)      state_d = WR;
        else if (cap_rd) state_d = RD_PEND;
      end
      WR: state_d = IDLE;
      RD_PEND: begin
        if (valid_pe) begin
          load_rsp = 1'b1;
          state_d  = RD_RESP;
        end
      end
      RD_RESP: begin
        if (valid_ne) begin
          clr_tags = 1'b1;
          take_wr  = cap_wr;
          take_rd  = cap_rd;
          if (cap_wr)      state_d = WR;
          else if (cap_rd) state_d = RD_PEND;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = regs[rd_addr[6:1]];
    if (rd_addr[0])             rdata = 16'h0000;
    else if (rd_addr == 7'h00)  rdata = RST_ID;
    else if (rd_addr == 7'h7C)  rdata = VID1;
    else if (rd_addr == 7'h7E)  rdata = VID2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r      <= 1'b0;
      reg_we       <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      rd_addr      <= '0;
      bus.out_tag1 <= 1'b0;
      bus.out_tag2 <= 1'b0;
      bus.out_slt1 <= '0;
      bus.out_slt2 <= '0;
    end else begin
      valid_r <= bus.valid;
      reg_we  <= take_wr;
      if (take_wr) begin
        reg_addr  <= cmd_addr;
        reg_wdata <= bus.in_slt2[19:4];
      end
      if (take_rd) rd_addr <= cmd_addr;
      if (load_rsp) begin
        bus.out_tag1 <= 1'b1;
        bus.out_tag2 <= 1'b1;
        bus.out_slt1 <= {1'b0, rd_addr, 12'h000};
        bus.out_slt2 <= {rdata, 4'h0};
      end else if (clr_tags) begin
        bus.out_tag1 <= 1'b0;
        bus.out_tag2 <= 1'b0;
      end
    end
  end

  // Commit happens at the end of the WR cycle, while reg_we is visible to the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 64; i++) regs[i] <= rst_val(i);
    end else if (state_q == WR) begin
      if (reg_addr == 7'h00) begin
        for (int unsigned i = 0; i < 64; i++) regs[i] <= rst_val(i);
      end else if (reg_addr != 7'h7C && reg_addr != 7'h7E) begin
        regs[reg_addr[6:1]] <= reg_wdata;
      end
    end
  end

endmodule

// File: tb/tb_ac97_codec_cra.sv
// Bench for ac97_codec_cra: vector table of frame commands with queued
// expectations checked by a monitor, plus hand-written reset sequences.
module tb_ac97_codec_cra;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_we;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;

  ac97_codec_cra_if bus();

  ac97_codec_cra #(
    .VID1(16'h4144), .VID2(16'h5370), .RST_ID(16'h0000), .VOL_RST(16'h8000)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          t1;
    bit          t2;
    logic [6:0]  addr;
    logic [15:0] data;
    bit          exp_we;
    bit          exp_rsp;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct { logic [6:0] addr; logic [15:0] data; } wr_exp_t;
  typedef struct { logic [19:0] slt1; logic [19:0] slt2; } rd_exp_t;

  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic frame(input bit t1, input bit t2, input logic [19:0] s1, input logic [19:0] s2);
    @(negedge clk);
    bus.in_tag1 = t1;
    bus.in_tag2 = t2;
    bus.in_slt1 = s1;
    bus.in_slt2 = s2;
    bus.valid   = 1'b1;
    repeat (4) @(negedge clk);
    bus.valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: pops expectations on each reg_we pulse and each response tag rise.
  int unsigned we_run = 0, tag_run = 0;
  always @(negedge clk) begin
    if (!rst) begin
      we_run  = 0;
      tag_run = 0;
    end else begin
      if (reg_we) begin
        if (we_run == 0) begin
          if (wr_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_we: got addr %h data %h expected no write", reg_addr, reg_wdata);
          end else begin
            wr_exp_t e;
            e = wr_q.pop_front();
            check("wr_addr", 32'(reg_addr), 32'(e.addr));
            check("wr_data", 32'(reg_wdata), 32'(e.data));
          end
        end
        we_run++;
      end else begin
        if (we_run != 0) check("we_len", we_run, 1);
        we_run = 0;
      end
      if (bus.out_tag1) begin
        if (tag_run == 0) begin
          if (rd_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_rsp: got slt1 %h slt2 %h expected no response", bus.out_slt1, bus.out_slt2);
          end else begin
            rd_exp_t e;
            e = rd_q.pop_front();
            check("rsp_slt1", 32'(bus.out_slt1), 32'(e.slt1));
            check("rsp_slt2", 32'(bus.out_slt2), 32'(e.slt2));
            check("rsp_tag2", 32'(bus.out_tag2), 1);
          end
        end
        tag_run++;
      end else begin
        if (tag_run != 0) begin
          check("tag_len", tag_run, 4);
          check("tag2_drop", 32'(bus.out_tag2), 0);
        end
        tag_run = 0;
      end
    end
  end

  vec_t vecs[$];

  initial begin
    int unsigned seen;
    vecs = '{
      '{1, 1, 0, 7'h02, 16'h0000, 0, 1, 16'h8000},
      '{1, 1, 0, 7'h7C, 16'h0000, 0, 1, 16'h4144},
      '{0, 1, 1, 7'h18, 16'h1234, 1, 0, 16'h0000},
      '{1, 1, 0, 7'h18, 16'h0000, 0, 1, 16'h1234},
      '{1, 1, 0, 7'h04, 16'h0000, 0, 1, 16'h8000},
      '{0, 1, 1, 7'h7E, 16'hFFFF, 1, 0, 16'h0000},
      '{1, 1, 0, 7'h7E, 16'h0000, 0, 1, 16'h5370},
      '{0, 1, 1, 7'h02, 16'h0000, 1, 0, 16'h0000},
      '{1, 1, 0, 7'h02, 16'h0000, 0, 1, 16'h0000},
      '{0, 1, 1, 7'h00, 16'hABCD, 1, 0, 16'h0000},
      '{1, 1, 0, 7'h02, 16'h0000, 0, 1, 16'h8000},
      '{1, 1, 0, 7'h18, 16'h0000, 0, 1, 16'h8000},
      '{0, 1, 0, 7'h10, 16'h5555, 0, 0, 16'h0000},
      '{1, 1, 0, 7'h10, 16'h0000, 0, 1, 16'h0000},
      '{0, 1, 1, 7'h10, 16'h5555, 1, 0, 16'h0000},
      '{0, 1, 1, 7'h11, 16'hAAAA, 0, 0, 16'h0000},
      '{1, 1, 0, 7'h10, 16'h0000, 0, 1, 16'h5555},
      '{1, 1, 0, 7'h05, 16'h0000, 0, 1, 16'h0000},
      '{1, 0, 0, 7'h02, 16'h0000, 0, 0, 16'h0000},
      '{1, 1, 0, 7'h00, 16'h0000, 0, 1, 16'h0000},
      '{0, 0, 0, 7'h00, 16'h0000, 0, 0, 16'h0000},
      '{0, 0, 0, 7'h00, 16'h0000, 0, 0, 16'h0000}
    };

    // Reset held low across a tagged write frame; nothing may commit.
    bus.valid   = 1'b0;
    bus.in_tag1 = 1'b0;
    bus.in_tag2 = 1'b0;
    bus.in_slt1 = '0;
    bus.in_slt2 = '0;
    repeat (2) @(negedge clk);
    bus.in_tag1 = 1'b1;
    bus.in_tag2 = 1'b1;
    bus.in_slt1 = {1'b0, 7'h02, 12'h000};
    bus.in_slt2 = {16'h1111, 4'h0};
    bus.valid   = 1'b1;
    repeat (3) @(negedge clk);
    bus.valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tags", {30'h0, bus.out_tag1, bus.out_tag2}, 0);
    check("rst_slt1", 32'(bus.out_slt1), 0);
    check("rst_slt2", 32'(bus.out_slt2), 0);
    check("rst_we", 32'(reg_we), 0);
    check("rst_wr_bus", {9'h0, reg_addr, reg_wdata}, 0);

    // Reset during RD_PEND abandons the read.
    frame(1'b1, 1'b0, {1'b1, 7'h18, 12'h000}, 20'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.in_tag1 = 1'b0;
    bus.valid   = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_tag1 || bus.out_tag2) seen++;
    end
    check("rd_pend_rst_tags", seen, 0);
    bus.valid = 1'b0;
    repeat (4) @(negedge clk);

    foreach (vecs[i]) begin
      logic [19:0] s1, s2;
      s1 = {vecs[i].rd, vecs[i].addr, 12'h5A5};
      s2 = {vecs[i].data, 4'hF};
      if (vecs[i].exp_we)  wr_q.push_back('{vecs[i].addr, vecs[i].data});
      if (vecs[i].exp_rsp) rd_q.push_back('{{1'b0, vecs[i].addr, 12'h000}, {vecs[i].exp_rdata, 4'h0}});
      frame(vecs[i].t1, vecs[i].t2, s1, s2);
    end

    // Valid held high for a long stretch changes nothing.
    bus.in_tag1 = 1'b1;
    bus.in_slt1 = {1'b1, 7'h02, 12'h000};
    bus.valid   = 1'b1;
    repeat (20) @(negedge clk);
    check("hold_high_tags", {30'h0, bus.out_tag1, bus.out_tag2}, 0);
    bus.in_tag1 = 1'b0;
    bus.valid   = 1'b0;
    repeat (6) @(negedge clk);

    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
